fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the fetch/decode pipeline register.
- Owns the architectural PC and issues one request at a time to a variable-latency instruction memory.
- Presents instr, pc_inc and valid to the F/D register, and holds an instruction locally while decode stalls.
- Handles branch/jump redirects from later stages, squashes stale memory responses, and stops fetching on HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, instr value driven whenever valid=0.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
stall_in  input  1  downstream cannot accept this cycle
redirect  input  1  branch/jump taken, load new PC
redirect_pc  input  16  redirect target; bit0 ignored and forced to 0
imem_req  output  1  single-cycle request pulse to instruction memory
imem_addr  output  16  fetch address, equals PC; valid when imem_req=1
imem_done  input  1  memory response valid; earliest one cycle after imem_req
imem_rdata  input  16  instruction word, valid with imem_done
instr  output  16  instruction to F/D register
pc_inc  output  16  PC+2 of the presented instruction
valid  output  1  instr/pc_inc are a real instruction
halted  output  1  fetch stopped on HALT

Behaviour:
- Reset (async, any time, including with a request outstanding):
  - state=FETCH, PC=RESET_PC, hold buffer cleared.
  - Outputs while rst=1: imem_req=0, valid=0, instr=NOP_INSTR, halted=0.
  - Any imem_done arriving after reset deasserts without a new request is ignored.
- States: FETCH, WAIT, HOLD, DRAIN, HALTED.
- FETCH:
  - imem_req=1, imem_addr=PC, then go to WAIT.
  - Redirect in FETCH: imem_req is still issued for the old PC, PC<=redirect_pc, go to DRAIN.
- WAIT (one request outstanding):
  - valid = imem_done; instr = imem_rdata; pc_inc = PC+2.
  - Accept occurs when valid=1 and stall_in=0:
    - If instr[15:11]==5'b00000 (HALT): go to HALTED, PC unchanged.
    - Otherwise PC<=PC+2 and go to FETCH.
  - If valid=1 and stall_in=1: capture imem_rdata into the hold buffer and go to HOLD.
  - If imem_done=0: stay in WAIT.
- HOLD:
  - valid=1, instr=hold buffer, pc_inc=PC+2; values stay stable while stall_in=1.
  - On accept, apply the same HALT/advance rules as WAIT.
- DRAIN:
  - valid=0, imem_req=0; wait for imem_done, discard the data, then go to FETCH.
- HALTED:
  - valid=0, imem_req=0, halted=1.
  - Leave only on redirect (PC<=redirect_pc, go to FETCH) or reset.
- Redirect priority: redirect overrides accept, stall and HALT in the same cycle. Forced valid=0 that cycle.
  - WAIT with imem_done=0 -> DRAIN.
  - WAIT with imem_done=1 -> response discarded, go to FETCH.
  - HOLD -> buffer discarded, go to FETCH.
  - HALTED -> FETCH.
  - Redirect during DRAIN: update PC and stay in DRAIN.
- Throughput: one instruction per two cycles minimum, since request and response are never in the same cycle. At most one outstanding request ever.
- Arithmetic:
  - pc_inc = PC+2 modulo 2^16; PC=16'hFFFE gives pc_inc=16'h0000.
  - PC is always even.
- When valid=0, instr=NOP_INSTR and pc_inc=PC+2.

Test Plan:
- Reset, then memory done 1 cycle after each req returning 16'h4000, 16'h4001: imem_addr sequence 0000, 0002; valid pulses carry pc_inc 0002 then 0004.
- Done arrives while stall_in=1 for 3 cycles: valid=1 held 4 cycles with constant instr/pc_inc; no new imem_req until the accept cycle passes.
- Redirect to 16'h0101 while WAIT with done 3 cycles later: late response discarded (valid stays 0); next imem_addr=0100.
- Redirect in the same cycle as done+accept: valid=0 that cycle, PC not advanced past the old instruction; next imem_addr=redirect target.
- Fetch 16'h0000 (HALT) at PC 0006: accepted once with pc_inc 0008, halted=1, no further imem_req for 10 cycles; redirect to 0020 resumes fetch at 0020 with halted=0.
- Assert rst mid-WAIT with PC=0x00A0 and RESET_PC=0x0010: outputs reset immediately; a stray imem_done after release is ignored; first imem_addr=0010. Separately, PC=FFFE wraps to pc_inc=0000.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
//
// Instruction-fetch stage sitting in front of the fetch/decode register.
// Owns the architectural PC and keeps at most one request outstanding to a
// variable-latency instruction memory. A response that decode cannot take
// is parked in a one-entry hold buffer. Redirects from later stages either
// drop the in-flight response (DRAIN) or restart fetch immediately. Fetch
// stops on a HALT opcode (instr[15:11] == 5'b00000) until the next redirect.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   stall_in     downstream cannot accept this cycle
//   redirect     branch/jump taken, load redirect_pc
//   redirect_pc  redirect target, bit 0 forced to 0
//   imem_req     single-cycle request pulse to instruction memory
//   imem_addr    fetch address (the PC), meaningful while imem_req=1
//   imem_done    memory response strobe, at least one cycle after imem_req
//   imem_rdata   instruction word, valid with imem_done
//   instr        instruction to the F/D register (NOP_INSTR when valid=0)
//   pc_inc       PC+2 of the presented instruction
//   valid        instr/pc_inc carry a real instruction
//   halted       fetch stopped on HALT
//
// state   | meaning
// --------+----------------------------------------------------------------
// FETCH   | issue a request for PC this cycle
// WAIT    | one request outstanding, response is passed straight through
// HOLD    | response captured while decode stalls, re-presented each cycle
// DRAIN   | one request outstanding whose response will be thrown away
// HALTED  | HALT was accepted, no fetching until a redirect

module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] pc_inc,
    output logic        valid,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] hold_buf;

    logic [15:0] redirect_tgt;
    logic [15:0] pc_plus2;
    logic        offer;
    logic [15:0] offer_word;
    logic        offer_is_halt;

    always_comb begin
        redirect_tgt  = {redirect_pc[15:1], 1'b0};
        pc_plus2      = pc + 16'd2;
        // An instruction is on offer either straight from memory (WAIT)
        // or from the hold buffer (HOLD).
        offer         = ((state == S_WAIT) && imem_done) || (state == S_HOLD);
        offer_word    = (state == S_HOLD) ? hold_buf : imem_rdata;
        offer_is_halt = (offer_word[15:11] == 5'b00000);
    end

    // valid/instr must follow imem_done in the same cycle, so they are
    // decoded from the state rather than registered. imem_req is masked by
    // rst because reset parks the FSM in FETCH.
    always_comb begin
        imem_req  = (state == S_FETCH) && !rst;
        imem_addr = pc;
        valid     = offer && !redirect;
        instr     = valid ? offer_word : NOP_INSTR;
        pc_inc    = pc_plus2;
        halted    = (state == S_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            hold_buf <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    // The request for the old PC still goes out, so its
                    // response has to be drained before refetching.
                    if (redirect) begin
                        pc    <= redirect_tgt;
                        state <= S_DRAIN;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirect) begin
                        pc    <= redirect_tgt;
                        state <= imem_done ? S_FETCH : S_DRAIN;
                    end else if (imem_done) begin
                        if (stall_in) begin
                            hold_buf <= imem_rdata;
                            state    <= S_HOLD;
                        end else if (offer_is_halt) begin
                            state <= S_HALTED;
                        end else begin
                            pc    <= pc_plus2;
                            state <= S_FETCH;
                        end
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        pc       <= redirect_tgt;
                        hold_buf <= '0;
                        state    <= S_FETCH;
                    end else if (!stall_in) begin
                        if (offer_is_halt) begin
                            state <= S_HALTED;
                        end else begin
                            pc    <= pc_plus2;
                            state <= S_FETCH;
                        end
                    end
                end

                S_DRAIN: begin
                    // A redirect only retargets the PC here; the stale
                    // response still has to be swallowed. If it lands in
                    // the same cycle as the redirect it is consumed too,
                    // otherwise the FSM would wait for a response that
                    // never comes.
                    if (redirect) begin
                        pc <= redirect_tgt;
                    end
                    if (imem_done) begin
                        state <= S_FETCH;
                    end
                end

                S_HALTED: begin
                    if (redirect) begin
                        pc    <= redirect_tgt;
                        state <= S_FETCH;
                    end
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//
// Directed scenarios followed by a randomized run. Every cycle the DUT
// outputs are compared against a behavioural model that tracks the fetch
// stage as a handful of flags (request due, request in flight, in-flight
// response to be dropped, word held, halted) plus the PC. A small memory
// responder answers each request after a 1..N cycle latency.

module tb_fetch_stage;

    localparam logic [15:0] RST_PC = 16'h0010;
    localparam logic [15:0] NOP    = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_done = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic        valid;
    logic        halted;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_in   (stall_in),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_done  (imem_done),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc_inc     (pc_inc),
        .valid      (valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model
    logic [15:0] m_pc;
    logic [15:0] m_word;
    bit          m_issue, m_busy, m_drop, m_have, m_halt;

    // memory responder
    bit          mem_pend;
    bit          stray;
    bit          rand_mode;
    int          mem_lat;
    logic [15:0] mem_word;
    int          lat_q[$];
    logic [15:0] word_q[$];

    // observations of the last cycle, for directed checks
    int          n_valid, n_req;
    logic        obs_valid, obs_req, obs_halted;
    logic [15:0] obs_addr, obs_pc_inc, obs_instr;

    task automatic model_reset();
        m_pc     = RST_PC;
        m_word   = '0;
        m_issue  = 1'b1;
        m_busy   = 1'b0;
        m_drop   = 1'b0;
        m_have   = 1'b0;
        m_halt   = 1'b0;
        mem_pend = 1'b0;
        lat_q.delete();
        word_q.delete();
    endtask

    task automatic apply_reset(input int ncyc);
        rst       = 1'b1;
        stall_in  = 1'b0;
        redirect  = 1'b0;
        imem_done = 1'b0;
        model_reset();
        #1;
        check_eq("rst_req",    16'(imem_req), 16'h0000);
        check_eq("rst_valid",  16'(valid),    16'h0000);
        check_eq("rst_instr",  instr,         NOP);
        check_eq("rst_halted", 16'(halted),   16'h0000);
        repeat (ncyc) @(posedge clk);
        #1;
        check_eq("rst_req_hold", 16'(imem_req), 16'h0000);
        rst = 1'b0;
    endtask

    task automatic accept_word(input logic [15:0] w);
        if (w[15:11] == 5'b00000) begin
            m_halt = 1'b1;
        end else begin
            m_pc    = m_pc + 16'd2;
            m_issue = 1'b1;
        end
    endtask

    // Called at posedge+1; drives one cycle, checks at the falling edge,
    // advances the model and returns at the next posedge+1.
    task automatic cycle(input bit st, input bit rd, input logic [15:0] rpc);
        logic        offered;
        logic [15:0] offer_w;
        logic        e_valid;
        logic [15:0] w;
        stall_in    = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_done   = 1'b0;
        imem_rdata  = 16'($urandom);
        if (stray) begin
            imem_done = 1'b1;
            stray     = 1'b0;
        end else if (mem_pend) begin
            mem_lat--;
            if (mem_lat == 0) begin
                imem_done  = 1'b1;
                imem_rdata = mem_word;
                mem_pend   = 1'b0;
            end
        end

        @(negedge clk);
        offered = !m_halt && (m_have || (m_busy && !m_drop && imem_done));
        offer_w = m_have ? m_word : imem_rdata;
        e_valid = offered && !rd;
        check_eq("req",    16'(imem_req), 16'(m_issue));
        check_eq("valid",  16'(valid),    16'(e_valid));
        check_eq("instr",  instr,         e_valid ? offer_w : NOP);
        check_eq("pc_inc", pc_inc,        m_pc + 16'd2);
        check_eq("halted", 16'(halted),   16'(m_halt));
        if (m_issue) check_eq("addr", imem_addr, m_pc);

        obs_valid  = valid;
        obs_req    = imem_req;
        obs_halted = halted;
        obs_addr   = imem_addr;
        obs_pc_inc = pc_inc;
        obs_instr  = instr;
        if (valid) n_valid++;
        if (imem_req) n_req++;

        if (imem_req === 1'b1) begin
            mem_pend = 1'b1;
            if (lat_q.size() > 0) mem_lat = lat_q.pop_front();
            else                  mem_lat = rand_mode ? int'($urandom_range(1, 4)) : 1;
            if (word_q.size() > 0) begin
                mem_word = word_q.pop_front();
            end else if (rand_mode) begin
                w = 16'($urandom);
                if ($urandom_range(0, 5) == 0) w[15:11] = 5'b00000;
                mem_word = w;
            end else begin
                mem_word = 16'h4800;
            end
        end

        if (rd) begin
            if (m_issue) begin
                m_issue = 1'b0;
                m_busy  = 1'b1;
                m_drop  = 1'b1;
            end else if (m_busy) begin
                if (imem_done) begin
                    m_busy  = 1'b0;
                    m_drop  = 1'b0;
                    m_issue = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
            end else begin
                m_have  = 1'b0;
                m_halt  = 1'b0;
                m_issue = 1'b1;
            end
            m_pc = {rpc[15:1], 1'b0};
        end else if (m_issue) begin
            m_issue = 1'b0;
            m_busy  = 1'b1;
            m_drop  = 1'b0;
        end else if (m_busy) begin
            if (imem_done) begin
                m_busy = 1'b0;
                if (m_drop) begin
                    m_drop  = 1'b0;
                    m_issue = 1'b1;
                end else if (st) begin
                    m_have = 1'b1;
                    m_word = imem_rdata;
                end else begin
                    accept_word(imem_rdata);
                end
            end
        end else if (m_have && !st) begin
            m_have = 1'b0;
            accept_word(m_word);
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        stray     = 1'b0;
        rand_mode = 1'b0;
        n_valid   = 0;
        n_req     = 0;
        #2;
        apply_reset(3);

        // back-to-back fetches with one-cycle memory
        word_q.push_back(16'h4000);
        word_q.push_back(16'h4001);
        cycle(0, 0, 16'h0);
        check_eq("s1_addr0", obs_addr, 16'h0010);
        cycle(0, 0, 16'h0);
        check_eq("s1_pcinc0", obs_pc_inc, 16'h0012);
        check_eq("s1_instr0", obs_instr, 16'h4000);
        cycle(0, 0, 16'h0);
        check_eq("s1_addr1", obs_addr, 16'h0012);
        cycle(0, 0, 16'h0);
        check_eq("s1_pcinc1", obs_pc_inc, 16'h0014);
        check_eq("s1_instr1", obs_instr, 16'h4001);

        // response lands during a three-cycle stall
        word_q.push_back(16'h1234);
        cycle(0, 0, 16'h0);
        n_valid = 0;
        n_req   = 0;
        cycle(1, 0, 16'h0);
        cycle(1, 0, 16'h0);
        cycle(1, 0, 16'h0);
        cycle(0, 0, 16'h0);
        check_eq("s2_valid_cycles", 16'(n_valid), 16'd4);
        check_eq("s2_no_req", 16'(n_req), 16'd0);
        check_eq("s2_instr", obs_instr, 16'h1234);
        check_eq("s2_pcinc", obs_pc_inc, 16'h0016);

        // redirect while waiting, late response dropped
        lat_q.push_back(4);
        cycle(0, 0, 16'h0);
        n_valid = 0;
        cycle(0, 1, 16'h0101);
        cycle(0, 0, 16'h0);
        cycle(0, 0, 16'h0);
        cycle(0, 0, 16'h0);
        check_eq("s3_dropped", 16'(n_valid), 16'd0);
        cycle(0, 0, 16'h0);
        check_eq("s3_req", 16'(obs_req), 16'h0001);
        check_eq("s3_addr", obs_addr, 16'h0100);

        // redirect in the same cycle as done+accept
        cycle(0, 1, 16'h0200);
        check_eq("s4_valid", 16'(obs_valid), 16'h0000);
        cycle(0, 0, 16'h0);
        check_eq("s4_addr", obs_addr, 16'h0200);

        // HALT at 0006, stays quiet, redirect resumes
        cycle(0, 1, 16'h0006);
        word_q.push_back(16'h0000);
        cycle(0, 0, 16'h0);
        check_eq("s5_addr", obs_addr, 16'h0006);
        cycle(0, 0, 16'h0);
        check_eq("s5_valid", 16'(obs_valid), 16'h0001);
        check_eq("s5_pcinc", obs_pc_inc, 16'h0008);
        n_req = 0;
        repeat (10) cycle(0, 0, 16'h0);
        check_eq("s5_no_req", 16'(n_req), 16'd0);
        check_eq("s5_halted", 16'(obs_halted), 16'h0001);
        cycle(0, 1, 16'h0020);
        cycle(0, 0, 16'h0);
        check_eq("s5_resume_addr", obs_addr, 16'h0020);
        check_eq("s5_unhalted", 16'(obs_halted), 16'h0000);

        // PC wrap at FFFE (bit 0 of the target is ignored)
        cycle(0, 1, 16'hFFFF);
        cycle(0, 0, 16'h0);
        check_eq("s6_addr", obs_addr, 16'hFFFE);
        check_eq("s6_pcinc", obs_pc_inc, 16'h0000);
        cycle(0, 0, 16'h0);
        check_eq("s6_valid_pcinc", obs_pc_inc, 16'h0000);

        // reset in the middle of a WAIT, stray done afterwards
        cycle(0, 0, 16'h0);
        cycle(0, 1, 16'h00A0);
        lat_q.push_back(5);
        cycle(0, 0, 16'h0);
        check_eq("s7_addr", obs_addr, 16'h00A0);
        cycle(0, 0, 16'h0);
        apply_reset(2);
        stray = 1'b1;
        cycle(0, 0, 16'h0);
        check_eq("s7_first_addr", obs_addr, RST_PC);
        check_eq("s7_stray_ignored", 16'(obs_valid), 16'h0000);
        cycle(0, 0, 16'h0);

        // randomized traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 4), ($urandom_range(0, 11) == 0), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
